// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard controller.
// NOP_INSTR is the bubble loaded into the FD register on reset and on FlushD.
package hazard_pkg;

   localparam logic [31:0] NOP_INSTR  = 32'hC000_0000;
   localparam int          DEF_REG_AW = 4;

   typedef enum logic {
      RUN     = 1'b0,
      MC_WAIT = 1'b1
   } hz_state_t;

endpackage

// File: rtl/hazard_perf_ctr.sv
// hazard_perf_ctr: 32-bit wrapping event counter.
// A synchronous load port allows presetting the count; it has priority over inc.
module hazard_perf_ctr (
   input  logic        CLK,
   input  logic        RST,
   input  logic        load,
   input  logic [31:0] load_val,
   input  logic        inc,
   output logic [31:0] count
);

   // Count events, wrapping naturally at 2^32; cleared by reset.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (inc) begin
         count <= count + 32'd1;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencing for the 5-stage pipeline.
// Resolves load-use hazards, flushes on taken branches and holds the front
// of the pipe while a multi-cycle op occupies E (MC_LAT cycles, 2..16).
// Optional build macro HAZ_PERF_EN adds LuStallCnt, McStallCnt and FlushCnt.
module pipe_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_AW = DEF_REG_AW,
   parameter int MC_LAT = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [REG_AW-1:0] Rs1D,
   input  logic [REG_AW-1:0] Rs2D,
   input  logic              UsesRs1D,
   input  logic              UsesRs2D,
   input  logic              McOpD,
   input  logic [REG_AW-1:0] RdE,
   input  logic              MemReadE,
   input  logic              BranchTakenE,
   output logic              StallF,
   output logic              StallD,
   output logic              StallE,
   output logic              FlushD,
   output logic              FlushE,
   output logic              FlushM,
   output logic              McBusy
`ifdef HAZ_PERF_EN
   ,
   output logic [31:0]       LuStallCnt,
   output logic [31:0]       McStallCnt,
   output logic [31:0]       FlushCnt
`endif
);

   // The counter only needs to hold MC_LAT-2; MC_LAT >= 2 keeps this >= 1 bit.
   localparam int             CNT_W   = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
   localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_LAT - 2);

   hz_state_t        state_reg;
   logic [CNT_W-1:0] mc_cnt_reg;

   logic lu;
   logic lu_stall;
   logic br_flush;
   logic mc_accept;

   // Load-use detection; x0 is hardwired to zero so it never hazards.
   assign lu = MemReadE && (RdE != '0) &&
               ((UsesRs1D && (Rs1D == RdE)) || (UsesRs2D && (Rs2D == RdE)));

   // Output decode by priority: branch, then load-use, then multi-cycle accept.
   always_comb begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FlushM    = 1'b0;
      lu_stall  = 1'b0;
      br_flush  = 1'b0;
      mc_accept = 1'b0;
      if (!RST) begin
         if (state_reg == RUN) begin
            if (BranchTakenE) begin
               // A multi-cycle op in D is on the wrong path and is dropped.
               FlushD   = 1'b1;
               FlushE   = 1'b1;
               br_flush = 1'b1;
            end else if (lu) begin
               // Hold D one cycle; McOpD is looked at again next cycle.
               StallF   = 1'b1;
               StallD   = 1'b1;
               FlushE   = 1'b1;
               lu_stall = 1'b1;
            end else if (McOpD) begin
               mc_accept = 1'b1;
            end
         end else begin
            // Branch/LU inputs are meaningless here: the E op is neither.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
         end
      end
   end

   // McBusy depends on state alone; async reset drives state to RUN at once.
   assign McBusy = (state_reg == MC_WAIT);

   // Sequencing FSM: accept in RUN, then count down MC_LAT-1 held cycles.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg  <= RUN;
         mc_cnt_reg <= '0;
      end else begin
         case (state_reg)
            RUN: begin
               if (mc_accept) begin
                  state_reg  <= MC_WAIT;
                  mc_cnt_reg <= MC_LOAD;
               end
            end
            MC_WAIT: begin
               if (mc_cnt_reg == '0) begin
                  state_reg <= RUN;
               end else begin
                  mc_cnt_reg <= mc_cnt_reg - 1'b1;
               end
            end
            default: begin
               state_reg  <= RUN;
               mc_cnt_reg <= '0;
            end
         endcase
      end
   end

`ifdef HAZ_PERF_EN
   logic [2:0]  perf_ev;
   logic [31:0] perf_cnt [3];

   assign perf_ev[0] = lu_stall;
   assign perf_ev[1] = McBusy;
   assign perf_ev[2] = br_flush;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_perf
         hazard_perf_ctr u_ctr (
            .CLK      (CLK),
            .RST      (RST),
            .load     (1'b0),
            .load_val (32'd0),
            .inc      (perf_ev[gi]),
            .count    (perf_cnt[gi])
         );
      end
   endgenerate

   assign LuStallCnt = perf_cnt[0];
   assign McStallCnt = perf_cnt[1];
   assign FlushCnt   = perf_cnt[2];
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for pipe_hazard_ctrl (MC_LAT=4).
// Control vector order: {StallF,StallD,StallE,FlushD,FlushE,FlushM,McBusy}.
module tb_pipe_hazard_ctrl;

   localparam int MC_LAT = 4;

   logic       CLK = 1'b0;
   logic       RST;
   logic [3:0] Rs1D, Rs2D, RdE;
   logic       UsesRs1D, UsesRs2D, McOpD, MemReadE, BranchTakenE;
   logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy;
`ifdef HAZ_PERF_EN
   logic [31:0] LuStallCnt, McStallCnt, FlushCnt;
   logic        w_load, w_inc;
   logic [31:0] w_val, w_count;
`endif

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Reference model state
   int m_rem = 0;
   int m_lu  = 0;
   int m_mc  = 0;
   int m_fl  = 0;

   logic [6:0] exp_q [$];

   always #5 CLK = ~CLK;

   pipe_hazard_ctrl #(.REG_AW(4), .MC_LAT(MC_LAT)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .Rs1D         (Rs1D),
      .Rs2D         (Rs2D),
      .UsesRs1D     (UsesRs1D),
      .UsesRs2D     (UsesRs2D),
      .McOpD        (McOpD),
      .RdE          (RdE),
      .MemReadE     (MemReadE),
      .BranchTakenE (BranchTakenE),
      .StallF       (StallF),
      .StallD       (StallD),
      .StallE       (StallE),
      .FlushD       (FlushD),
      .FlushE       (FlushE),
      .FlushM       (FlushM),
      .McBusy       (McBusy)
`ifdef HAZ_PERF_EN
      ,
      .LuStallCnt   (LuStallCnt),
      .McStallCnt   (McStallCnt),
      .FlushCnt     (FlushCnt)
`endif
   );

`ifdef HAZ_PERF_EN
   hazard_perf_ctr u_wrap (
      .CLK      (CLK),
      .RST      (RST),
      .load     (w_load),
      .load_val (w_val),
      .inc      (w_inc),
      .count    (w_count)
   );
`endif

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive, predict, push; sample mid-cycle, pop, compare.
   task automatic cycle(input logic rst, input logic [3:0] rs1, input logic [3:0] rs2,
                        input logic u1, input logic u2, input logic mc,
                        input logic [3:0] rde, input logic mr, input logic br);
      logic [6:0] e, got;
      logic       lu_m;
      RST = rst; Rs1D = rs1; Rs2D = rs2; UsesRs1D = u1; UsesRs2D = u2;
      McOpD = mc; RdE = rde; MemReadE = mr; BranchTakenE = br;
      lu_m = mr && (rde != 4'd0) && ((u1 && rs1 == rde) || (u2 && rs2 == rde));
      e = 7'b0000000;
      if (rst) begin
         m_rem = 0; m_lu = 0; m_mc = 0; m_fl = 0;
      end else if (m_rem != 0) begin
         e = 7'b1110011; m_rem--; m_mc++;
      end else if (br) begin
         e = 7'b0001100; m_fl++;
      end else if (lu_m) begin
         e = 7'b1100100; m_lu++;
      end else if (mc) begin
         m_rem = MC_LAT - 1;
      end
      exp_q.push_back(e);
      @(negedge CLK);
      got = {StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy};
      e = exp_q.pop_front();
      $display("cyc %0d rst=%b mc=%b br=%b mr=%b rd=%0d -> ctl=%b exp=%b",
               cyc, rst, mc, br, mr, rde, got, e);
      check_val($sformatf("ctl_c%0d", cyc), {25'd0, got}, {25'd0, e});
      cyc++;
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
   endtask

   initial begin
      RST = 1'b1; Rs1D = '0; Rs2D = '0; RdE = '0;
      UsesRs1D = 0; UsesRs2D = 0; McOpD = 0; MemReadE = 0; BranchTakenE = 0;
`ifdef HAZ_PERF_EN
      w_load = 0; w_inc = 0; w_val = '0;
`endif
      @(posedge CLK); #1;
      // Reset held with hazard-causing inputs: outputs forced low
      cycle(1'b1, 4'd5, 4'd0, 1'b1, 1'b0, 1'b1, 4'd5, 1'b1, 1'b1);
      cycle(1'b1, 4'd5, 4'd0, 1'b1, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0);
      idle();
      // Load-use via Rs1, one cycle, then bubble
      cycle(1'b0, 4'd5, 4'd0, 1'b1, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0);
      cycle(1'b0, 4'd5, 4'd0, 1'b1, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0);
      // RdE=0 never hazards
      cycle(1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
      // Load-use via Rs2; Rs1 match with UsesRs1D=0 does not hazard
      cycle(1'b0, 4'd3, 4'd7, 1'b0, 1'b1, 1'b0, 4'd7, 1'b1, 1'b0);
      cycle(1'b0, 4'd7, 4'd2, 1'b0, 1'b1, 1'b0, 4'd7, 1'b1, 1'b0);
      // Branch beats load-use
      cycle(1'b0, 4'd5, 4'd0, 1'b1, 1'b0, 1'b0, 4'd5, 1'b1, 1'b1);
      // Multi-cycle op, branch/LU ignored while waiting, back-to-back op
      cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      cycle(1'b0, 4'd5, 4'd0, 1'b1, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0);
      cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
      cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      idle(); idle(); idle(); idle();
      // Branch in accept cycle: op discarded
      cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
      idle();
      // LU defers the op; accepted the next cycle
      cycle(1'b0, 4'd9, 4'd0, 1'b1, 1'b0, 1'b1, 4'd9, 1'b1, 1'b0);
      cycle(1'b0, 4'd9, 4'd0, 1'b1, 1'b0, 1'b1, 4'd9, 1'b0, 1'b0);
      idle(); idle(); idle(); idle();
      // Reset in cycle t+2 of an op abandons it
      cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      idle();
      cycle(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      idle(); idle();
      // Directed counter scenario: 3 LU stalls, one op, 2 branches
      for (int i = 0; i < 3; i++)
         cycle(1'b0, 4'd4, 4'd0, 1'b1, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0);
      cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      idle(); idle(); idle();
      cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      idle();
`ifdef HAZ_PERF_EN
      check_val("lu_cnt_dir", LuStallCnt, 32'd3);
      check_val("mc_cnt_dir", McStallCnt, 32'd3);
      check_val("fl_cnt_dir", FlushCnt, 32'd2);
`endif
      // Random traffic over a small register space
      for (int i = 0; i < 200; i++) begin
         cycle(($urandom_range(0, 39) == 0),
               4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 5) == 0),
               4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0));
      end
      idle(); idle(); idle(); idle();
`ifdef HAZ_PERF_EN
      check_val("lu_cnt", LuStallCnt, 32'(m_lu));
      check_val("mc_cnt", McStallCnt, 32'(m_mc));
      check_val("fl_cnt", FlushCnt, 32'(m_fl));
      // Wrap check on a standalone counter
      w_load = 1; w_val = 32'hFFFF_FFFF;
      @(posedge CLK); #1;
      w_load = 0;
      check_val("wrap_pre", w_count, 32'hFFFF_FFFF);
      w_inc = 1;
      @(posedge CLK); #1;
      w_inc = 0;
      check_val("wrap_post", w_count, 32'd0);
`endif
      check_val("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
